// File: rtl/alu_seq_core.sv
// Handshaked WIDTH-bit ALU: single-cycle logic/arith ops, iterative shift-add MUL
// and restoring DIV (one bit per cycle), with registered result and status flags.
module alu_seq_core #(
  parameter int         WIDTH   = 8,
  parameter logic [7:0] ENC_KEY = 8'hAB
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 carry,
  output logic                 overflow,
  output logic                 zero,
  output logic                 div_by_zero
);

  localparam int                 CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]      LAST = CW'(WIDTH - 1);
  localparam logic [2*WIDTH-1:0] KEY  = (2*WIDTH)'(ENC_KEY);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;
  localparam logic [3:0] OP_ENC = 4'd8;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic                 r_isDiv;
  logic [WIDTH-1:0]     r_opA;
  logic [WIDTH-1:0]     r_opB;
  logic [WIDTH-1:0]     r_rem;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0]   r_acc;

  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_diff;
  logic [2*WIDTH-1:0]   w_scResult;
  logic                 w_scCarry;
  logic                 w_scOv;
  logic [WIDTH:0]       w_remShift;
  logic                 w_divGe;
  logic [WIDTH-1:0]     w_remSub;
  logic [WIDTH-1:0]     w_remNext;
  logic [WIDTH-1:0]     w_quoNext;
  logic [2*WIDTH-1:0]   w_accNext;
  logic [2*WIDTH-1:0]   w_execResult;

  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    w_scResult = '0;
    w_scCarry  = 1'b0;
    w_scOv     = 1'b0;
    case (op)
      OP_ADD: begin
        w_scResult = {{WIDTH{1'b0}}, w_sum[WIDTH-1:0]};
        w_scCarry  = w_sum[WIDTH];
        w_scOv     = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_scResult = {{WIDTH{1'b0}}, w_diff[WIDTH-1:0]};
        w_scCarry  = w_diff[WIDTH];
        w_scOv     = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  w_scResult = {{WIDTH{1'b0}}, a & b};
      OP_OR:   w_scResult = {{WIDTH{1'b0}}, a | b};
      OP_XOR:  w_scResult = {{WIDTH{1'b0}}, a ^ b};
      OP_NOT:  w_scResult = {{WIDTH{1'b0}}, ~a};
      OP_ENC:  w_scResult = {a, b} ^ KEY;
      default: w_scResult = '0;
    endcase
  end

  // The partial remainder is always below the divisor, so the trial
  // subtraction result fits in WIDTH bits whenever it is kept.
  assign w_remShift   = {r_rem, r_opA[WIDTH-1]};
  assign w_divGe      = w_remShift >= {1'b0, r_opB};
  assign w_remSub     = w_remShift[WIDTH-1:0] - r_opB;
  assign w_remNext    = w_divGe ? w_remSub : w_remShift[WIDTH-1:0];
  assign w_quoNext    = {r_opA[WIDTH-2:0], w_divGe};
  assign w_accNext    = r_opA[0] ? (r_acc + r_mcand) : r_acc;
  assign w_execResult = r_isDiv ? {w_quoNext, w_remNext} : w_accNext;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_isDiv     <= 1'b0;
      r_opA       <= '0;
      r_opB       <= '0;
      r_rem       <= '0;
      r_mcand     <= '0;
      r_acc       <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      result      <= '0;
      carry       <= 1'b0;
      overflow    <= 1'b0;
      zero        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_opA    <= a;
            r_opB    <= b;
            in_ready <= 1'b0;
            if (op == OP_MUL || op == OP_DIV) begin
              r_state <= EXEC;
              r_cnt   <= '0;
              r_isDiv <= (op == OP_DIV);
              r_acc   <= '0;
              r_rem   <= '0;
              r_mcand <= {{WIDTH{1'b0}}, b};
            end else begin
              r_state     <= DONE;
              out_valid   <= 1'b1;
              result      <= w_scResult;
              carry       <= w_scCarry;
              overflow    <= w_scOv;
              zero        <= (w_scResult == '0);
              div_by_zero <= 1'b0;
            end
          end
        end
        // The final iteration registers its own result so DONE follows directly.
        EXEC: begin
          r_cnt   <= r_cnt + 1'b1;
          r_acc   <= w_accNext;
          r_mcand <= r_mcand << 1;
          r_rem   <= w_remNext;
          r_opA   <= r_isDiv ? w_quoNext : (r_opA >> 1);
          if (r_cnt == LAST) begin
            r_state     <= DONE;
            out_valid   <= 1'b1;
            result      <= w_execResult;
            carry       <= 1'b0;
            overflow    <= 1'b0;
            zero        <= (w_execResult == '0);
            div_by_zero <= r_isDiv && (r_opB == '0);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state   <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
